rv32_register_file: RTL and testbench



---
 rtl/rv_pkg.sv | 10 +
 rtl/rv32_register_file.sv | 40 ++++
 tb/tb_rv32_register_file.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I datapath constants for the multicycle core.
package rv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(0);

endpackage : rv_pkg

// File: rtl/rv32_register_file.sv
// RV32I integer register file: 32 x XLEN, two combinational read ports,
// one synchronous write port, x0 hardwired to zero, no write-to-read bypass.
module rv32_register_file
  import rv_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [REG_ADDR_W-1:0] aa_i,
  input  logic [REG_ADDR_W-1:0] ab_i,
  input  logic [REG_ADDR_W-1:0] aw_i,
  input  logic                  wren_i,
  input  logic [XLEN-1:0]       wrdata_i,
  output logic [XLEN-1:0]       a_o,
  output logic [XLEN-1:0]       b_o
);

  // Element 0 is never written, so it holds the zero left by reset.
  logic [XLEN-1:0] reg_array_r [0:NUM_REGS-1];

  logic            wr_hit_c;

  // Writes to x0 are dropped here rather than masked on read.
  assign wr_hit_c = wren_i && (aw_i != ZERO_REG);

  // Async clear of every entry; rd writeback on the rising edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        reg_array_r[i] <= '0;
      end
    end else if (wr_hit_c) begin
      reg_array_r[aw_i] <= wrdata_i;
    end
  end

  // Combinational operand reads; address 0 forced to zero for robustness.
  assign a_o = (aa_i == ZERO_REG) ? XLEN'(0) : reg_array_r[aa_i];
  assign b_o = (ab_i == ZERO_REG) ? XLEN'(0) : reg_array_r[ab_i];

endmodule : rv32_register_file

// File: tb/tb_rv32_register_file.sv
// Directed self-checking bench for rv32_register_file.
module tb_rv32_register_file;

  logic        clk_i;
  logic        rst_ni;
  logic [4:0]  aa_i;
  logic [4:0]  ab_i;
  logic [4:0]  aw_i;
  logic        wren_i;
  logic [31:0] wrdata_i;
  logic [31:0] a_o;
  logic [31:0] b_o;

  int unsigned n_checks;
  int unsigned n_errors;

  rv32_register_file dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .aa_i     (aa_i),
    .ab_i     (ab_i),
    .aw_i     (aw_i),
    .wren_i   (wren_i),
    .wrdata_i (wrdata_i),
    .a_o      (a_o),
    .b_o      (b_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 32'h%08h expected 32'h%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_ni   = 1'b0;
    aa_i     = 5'd0;
    ab_i     = 5'd7;
    aw_i     = 5'd0;
    wren_i   = 1'b0;
    wrdata_i = 32'h0;

    // Reset state
    #2;
    check_eq("rst_a", a_o, 32'h0);
    check_eq("rst_b", b_o, 32'h0);
    tick();
    rst_ni = 1'b1;

    // wren=0 changes nothing
    aa_i = 5'd0; ab_i = 5'd2; aw_i = 5'd1; wrdata_i = 32'h000000FF; wren_i = 1'b0;
    tick();
    check_eq("nowr_a", a_o, 32'h0);
    check_eq("nowr_b", b_o, 32'h0);
    check_eq("nowr_x1", dut.reg_array_r[1], 32'h0);

    // Write x2, read unrelated regs, then x2
    aw_i = 5'd2; wren_i = 1'b1; wrdata_i = 32'h000000FF; aa_i = 5'd4; ab_i = 5'd5;
    tick();
    check_eq("wr2_a", a_o, 32'h0);
    check_eq("wr2_b", b_o, 32'h0);
    aa_i = 5'd2;
    #1;
    check_eq("rd2_a", a_o, 32'h000000FF);

    // Write x3 while reading x2; no bypass before the edge
    ab_i = 5'd3; aw_i = 5'd3; wrdata_i = 32'h00000FFF;
    #1;
    check_eq("wr3_a_pre", a_o, 32'h000000FF);
    check_eq("wr3_nobyp", b_o, 32'h0);
    tick();
    check_eq("wr3_b_post", b_o, 32'h00000FFF);

    // Write to x0 is discarded
    aw_i = 5'd0; wrdata_i = 32'hFFFFFFFF; wren_i = 1'b1;
    tick();
    wren_i = 1'b0;
    aa_i = 5'd0; ab_i = 5'd3;
    #1;
    check_eq("x0_arr", dut.reg_array_r[0], 32'h0);
    check_eq("x0_a", a_o, 32'h0);
    check_eq("x0_b3", b_o, 32'h00000FFF);

    // x31 on both ports, then async reset without a clock edge
    aw_i = 5'd31; wrdata_i = 32'hDEADBEEF; wren_i = 1'b1;
    tick();
    wren_i = 1'b0;
    aa_i = 5'd31; ab_i = 5'd31;
    #1;
    check_eq("x31_a", a_o, 32'hDEADBEEF);
    check_eq("x31_b", b_o, 32'hDEADBEEF);
    rst_ni = 1'b0;
    #1;
    check_eq("arst_a", a_o, 32'h0);
    check_eq("arst_b", b_o, 32'h0);
    check_eq("arst_x3", dut.reg_array_r[3], 32'h0);
    #1;
    rst_ni = 1'b1;

    // Fill x1..x31 with their index, read every (i, 31-i) pair
    wren_i = 1'b1;
    for (int i = 1; i < 32; i++) begin
      aw_i = 5'(i);
      wrdata_i = 32'(i);
      tick();
    end
    wren_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      aa_i = 5'(i);
      ab_i = 5'(31 - i);
      #1;
      check_eq($sformatf("pair_a%0d", i), a_o, 32'(i));
      check_eq($sformatf("pair_b%0d", 31 - i), b_o, 32'(31 - i));
    end

    // Held wren=0 across edges keeps contents
    aw_i = 5'd7; wrdata_i = 32'hA5A5A5A5; aa_i = 5'd7;
    tick();
    check_eq("hold_x7", a_o, 32'd7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_rv32_register_file
